rggen_apb_master: RTL and testbench
===================================

RGGEN_APB_MASTER -- requirements
Module: rggen_apb_master

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 16: APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width; a multiple of 8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 0: ACCESS-phase wait limit; 0 disables the timeout.
REQ-004 The block SHALL provide port clk, input, 1: clock; one clock domain.
REQ-005 The block SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL provide port i_cmd_valid, input, 1: command offered.
REQ-007 The block SHALL provide port o_cmd_ready, output, 1: command accepted.
REQ-008 The block SHALL provide port i_cmd_write, input, 1: 1 = write, 0 = read.
REQ-009 The block SHALL provide port i_cmd_address, input, ADDRESS_WIDTH: byte address.
REQ-010 The block SHALL provide port i_cmd_write_data, input, DATA_WIDTH: write data.
REQ-011 The block SHALL provide port i_cmd_strobe, input, DATA_WIDTH/8: byte strobes.
REQ-012 The block SHALL provide port o_rsp_valid, output, 1: response available.
REQ-013 The block SHALL provide port i_rsp_ready, input, 1: response consumed.
REQ-014 The block SHALL provide port o_rsp_read_data, output, DATA_WIDTH: read data; 0 for writes.
REQ-015 The block SHALL provide port o_rsp_status, output, 2: OKAY=0, SLVERR=1, TIMEOUT=2.
REQ-016 The block SHALL provide port apb_if, rggen_apb_if.master, –: APB initiator (psel, penable, paddr, pwrite, pwdata, pstrb, pready, prdata, pslverr).

Function
REQ-017 The block SHALL implement FSM states IDLE, SETUP, ACCESS and RESPONSE.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where i_cmd_valid && o_cmd_ready, and the FSM SHALL go to SETUP on the next cycle.
REQ-019 On acceptance, address, write, write data and strobe SHALL be registered; the command inputs SHALL be ignored until the next IDLE.
REQ-020 SETUP SHALL drive psel=1 and penable=0, last exactly one cycle, then go to ACCESS.
REQ-021 ACCESS SHALL drive psel=1 and penable=1; paddr, pwrite, pwdata and pstrb SHALL stay stable from SETUP through the end of ACCESS.
REQ-022 In ACCESS with pready=1, the block SHALL capture prdata (reads only; 0 for writes), set status to SLVERR if pslverr else OKAY, and go to RESPONSE.
REQ-023 When TIMEOUT_CYCLES>0 and pready stays 0 for TIMEOUT_CYCLES consecutive ACCESS cycles, the block SHALL end the transfer (psel=0 next cycle), set status TIMEOUT with read data 0, and go to RESPONSE.
REQ-024 RESPONSE SHALL hold o_rsp_valid=1 with stable data and status until i_rsp_ready=1, then go to IDLE.
REQ-025 The minimum command-accept to o_rsp_valid latency SHALL be 3 cycles (SETUP, ACCESS, RESPONSE), and the minimum back-to-back command spacing SHALL be 4 cycles.
REQ-026 pwrite=0 SHALL force pstrb to all-zero.
REQ-027 Outside SETUP and ACCESS, the block SHALL drive psel=0 and penable=0, and paddr, pwdata and pstrb SHALL hold their last values.
REQ-028 The timeout counter SHALL saturate and never wrap; a pready that arrives on the same cycle the counter reaches the limit SHALL win (normal completion).

Reset
REQ-029 While rst=1 the block SHALL enter IDLE on the next clk edge, regardless of state.
REQ-030 During reset, o_cmd_ready SHALL be 0, o_rsp_valid=0, o_rsp_read_data=0, o_rsp_status=OKAY, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, and the timeout counter SHALL be 0.
REQ-031 Reset during SETUP, ACCESS or RESPONSE SHALL abandon the transfer; no response SHALL be emitted for it.
REQ-032 o_cmd_ready SHALL rise on the first cycle after rst deasserts.

Structure
REQ-033 Package rggen_apb_master_pkg SHALL hold the FSM state enum and the response-status enum.
REQ-034 Sub-module rggen_apb_master_timeout_counter SHALL implement the clear, enable and saturating-count logic; TIMEOUT_CYCLES=0 SHALL tie its expired output to 0.
REQ-035 All state SHALL be in always_ff on clk with synchronous rst; there SHALL be no latches.

Verification
REQ-036 Write: cmd write, address 0x0010, data 0xA5A5_5A5A, strobe 0xF; slave pready=1 at the first ACCESS cycle -> exactly one SETUP cycle, one ACCESS cycle, then o_rsp_valid with status OKAY and read data 0.
REQ-037 Read with 3 wait states: address 0x0004, prdata 0x1234_5678 -> ACCESS held 4 cycles with paddr stable, then response read data 0x1234_5678, status OKAY.
REQ-038 Slave error: read returning pslverr=1 -> status SLVERR; the next command is accepted only after the i_rsp_ready handshake.
REQ-039 Timeout: TIMEOUT_CYCLES=8, pready held 0 -> psel drops after 8 ACCESS cycles, status TIMEOUT, read data 0; a second run with pready on cycle 8 -> status OKAY.
REQ-040 Backpressure and reset: i_rsp_ready held 0 for 5 cycles -> response stays stable and o_cmd_ready=0; rst asserted mid-ACCESS -> psel=0 next cycle, no response, o_cmd_ready=1 after release.

Source files
------------

// File: rtl/rggen_apb_master_pkg.sv
// Shared types for the APB master: FSM state encoding, response status codes,
// and a helper for sizing the ACCESS-phase wait counter.
package rggen_apb_master_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_SETUP    = 2'd1,
    STATE_ACCESS   = 2'd2,
    STATE_RESPONSE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OKAY    = 2'd0,
    STATUS_SLVERR  = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } status_e;

  // Counter width able to hold values 0..limit (at least one bit).
  function automatic int unsigned count_width(int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rggen_apb_master_if.sv
// APB bus bundle between an initiator (master modport) and a completer
// (slave modport).
//   psel/penable/paddr/pwrite/pwdata/pstrb : initiator -> completer
//   pready/prdata/pslverr                  : completer -> initiator
interface rggen_apb_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     pwrite;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [STRB_WIDTH-1:0]    pstrb;
  logic                     pready;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_master_timeout_counter.sv
// Counts consecutive ACCESS cycles without pready and flags when the limit is
// reached. The count saturates; TIMEOUT_CYCLES = 0 disables the feature.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count (held while not in ACCESS)
//   enable    : ACCESS cycle with pready low
//   expired_c : this enabled cycle is the TIMEOUT_CYCLES-th one in a row
module rggen_apb_master_timeout_counter
  import rggen_apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);
  localparam int unsigned COUNT_WIDTH = count_width(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] count;

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign count         = '0;
    assign expired_c     = 1'b0;
    assign unused_inputs = ^{clk, rst, clear, enable, count};
  end else begin : g_enabled
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    // Saturating count of stalled ACCESS cycles.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count <= '0;
      end else if (enable && (count != LIMIT)) begin
        count <= count + COUNT_WIDTH'(1);
      end
    end

    // count holds the stalls seen before this cycle, so this cycle is the last
    // one allowed; a pready now clears enable and wins over the timeout.
    assign expired_c = enable && (count >= (LIMIT - COUNT_WIDTH'(1)));
  end

endmodule

// File: rtl/rggen_apb_master.sv
// Command/response front end driving a single APB initiator port.
//   clk, rst          : clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready : command channel (valid/ready)
//   o_rsp_*/i_rsp_ready : response channel (valid/ready), status OKAY/SLVERR/TIMEOUT
//   apb_if            : APB initiator (master modport)
module rggen_apb_master
  import rggen_apb_master_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]   i_cmd_address,
  input  logic [DATA_WIDTH-1:0]      i_cmd_write_data,
  input  logic [DATA_WIDTH/8-1:0]    i_cmd_strobe,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [DATA_WIDTH-1:0]      o_rsp_read_data,
  output logic [1:0]                 o_rsp_status,
  rggen_apb_if.master                apb_if
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e state;
  logic   timeout_clear_c;
  logic   timeout_enable_c;
  logic   timeout_expired_c;

  assign timeout_clear_c  = (state != STATE_ACCESS);
  assign timeout_enable_c = (state == STATE_ACCESS) && !apb_if.pready;

  rggen_apb_master_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (timeout_clear_c),
    .enable    (timeout_enable_c),
    .expired_c (timeout_expired_c)
  );

  // Transfer FSM; the APB request fields double as the command holding
  // registers, so they stay put outside SETUP/ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= STATE_IDLE;
      o_cmd_ready     <= 1'b0;
      o_rsp_valid     <= 1'b0;
      o_rsp_read_data <= '0;
      o_rsp_status    <= STATUS_OKAY;
      apb_if.psel     <= 1'b0;
      apb_if.penable  <= 1'b0;
      apb_if.paddr    <= '0;
      apb_if.pwrite   <= 1'b0;
      apb_if.pwdata   <= '0;
      apb_if.pstrb    <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (o_cmd_ready && i_cmd_valid) begin
            state          <= STATE_SETUP;
            o_cmd_ready    <= 1'b0;
            apb_if.psel    <= 1'b1;
            apb_if.penable <= 1'b0;
            apb_if.paddr   <= i_cmd_address;
            apb_if.pwrite  <= i_cmd_write;
            apb_if.pwdata  <= i_cmd_write_data;
            // Reads never carry byte strobes.
            apb_if.pstrb   <= i_cmd_write ? i_cmd_strobe : STRB_WIDTH'(0);
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end

        STATE_SETUP: begin
          state          <= STATE_ACCESS;
          apb_if.penable <= 1'b1;
        end

        STATE_ACCESS: begin
          if (apb_if.pready) begin
            state           <= STATE_RESPONSE;
            apb_if.psel     <= 1'b0;
            apb_if.penable  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_read_data <= apb_if.pwrite ? DATA_WIDTH'(0) : apb_if.prdata;
            o_rsp_status    <= apb_if.pslverr ? STATUS_SLVERR : STATUS_OKAY;
          end else if (timeout_expired_c) begin
            state           <= STATE_RESPONSE;
            apb_if.psel     <= 1'b0;
            apb_if.penable  <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_read_data <= '0;
            o_rsp_status    <= STATUS_TIMEOUT;
          end
        end

        STATE_RESPONSE: begin
          if (i_rsp_ready) begin
            state       <= STATE_IDLE;
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
          end
        end

        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_master.sv
// Self-checking bench for rggen_apb_master (TIMEOUT_CYCLES = 8). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_rggen_apb_master;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 32;
  localparam int          TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_write_data;
  logic [3:0]    cmd_strobe;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_read_data;
  logic [1:0]    rsp_status;

  int tests    = 0;
  int failures = 0;

  rggen_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  rggen_apb_master #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_write      (cmd_write),
    .i_cmd_address    (cmd_address),
    .i_cmd_write_data (cmd_write_data),
    .i_cmd_strobe     (cmd_strobe),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_read_data  (rsp_read_data),
    .o_rsp_status     (rsp_status),
    .apb_if           (apb)
  );

  always #5 clk = ~clk;

  // Reference: number of ACCESS cycles for a slave that waits w cycles.
  function automatic int exp_access_cycles(int w);
    return (w >= TIMEOUT) ? TIMEOUT : w + 1;
  endfunction

  // Reference: response status.
  function automatic logic [1:0] exp_status(int w, logic err);
    if (w >= TIMEOUT) return 2'd2;
    return err ? 2'd1 : 2'd0;
  endfunction

  // One complete command with a slave inserting w wait states, then a response
  // held for rsp_delay cycles before it is consumed.
  task automatic do_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] strb, input int w,
                        input logic err, input logic [DW-1:0] rd, input int rsp_delay);
    int          guard;
    int          k;
    bit          done;
    logic [3:0]  e_strb;
    logic [1:0]  e_status;
    logic [DW-1:0] e_rdata;
    int          e_k;
    logic [DW-1:0] held_data;
    logic [1:0]  held_status;

    e_strb   = wr ? strb : 4'h0;
    e_k      = exp_access_cycles(w);
    e_status = exp_status(w, err);
    e_rdata  = (wr || (w >= TIMEOUT)) ? '0 : rd;

    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_write      = wr;
    cmd_address    = addr;
    cmd_write_data = data;
    cmd_strobe     = strb;
    rsp_ready      = 1'b0;
    apb.pready     = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL %s accept: cmd_ready never rose", name);
      cmd_valid = 1'b0;
      return;
    end

    // SETUP cycle; scramble command inputs to show they are ignored.
    @(negedge clk);
    cmd_valid      = 1'b0;
    cmd_address    = AW'($urandom);
    cmd_write_data = $urandom;
    cmd_strobe     = 4'($urandom);
    cmd_write      = ~wr;
    apb.prdata     = rd;
    apb.pslverr    = err;
    tests++;
    if ({apb.psel, apb.penable, cmd_ready, apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb} !==
        {1'b1, 1'b0, 1'b0, addr, wr, data, e_strb}) begin
      failures++;
      $display("FAIL %s setup: psel=%b penable=%b ready=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h, want 1 0 0 %h %b %h %h",
               name, apb.psel, apb.penable, cmd_ready, apb.paddr, apb.pwrite, apb.pwdata,
               apb.pstrb, addr, wr, data, e_strb);
    end

    // ACCESS cycles until psel drops.
    k = 0;
    done = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (apb.psel === 1'b1 && apb.penable === 1'b1) begin
        k++;
        apb.pready = (k == w + 1);
        tests++;
        if ({apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb, rsp_valid} !== {addr, wr, data, e_strb, 1'b0}) begin
          failures++;
          $display("FAIL %s access%0d: paddr=%h pwrite=%b pwdata=%h pstrb=%h rsp_valid=%b, want %h %b %h %h 0",
                   name, k, apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb, rsp_valid,
                   addr, wr, data, e_strb);
        end
      end else begin
        done = 1;
      end
    end
    apb.pready = 1'b0;
    tests++;
    if (k !== e_k) begin
      failures++;
      $display("FAIL %s access_cycles: got %0d, want %0d", name, k, e_k);
    end
    tests++;
    if ({rsp_valid, rsp_status, rsp_read_data, apb.psel, apb.penable} !== {1'b1, e_status, e_rdata, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s response: valid=%b status=%0d rdata=%h psel=%b penable=%b, want 1 %0d %h 0 0",
               name, rsp_valid, rsp_status, rsp_read_data, apb.psel, apb.penable, e_status, e_rdata);
    end

    held_data   = rsp_read_data;
    held_status = rsp_status;
    for (int d = 0; d < rsp_delay; d++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_status, rsp_read_data, cmd_ready} !== {1'b1, held_status, held_data, 1'b0}) begin
        failures++;
        $display("FAIL %s hold%0d: valid=%b status=%0d rdata=%h ready=%b, want 1 %0d %h 0",
                 name, d, rsp_valid, rsp_status, rsp_read_data, cmd_ready, held_status, held_data);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if ({rsp_valid, cmd_ready, apb.psel, apb.paddr, apb.pwdata, apb.pstrb} !== {1'b0, 1'b1, 1'b0, addr, data, e_strb}) begin
      failures++;
      $display("FAIL %s release: valid=%b ready=%b psel=%b paddr=%h pwdata=%h pstrb=%h, want 0 1 0 %h %h %h",
               name, rsp_valid, cmd_ready, apb.psel, apb.paddr, apb.pwdata, apb.pstrb, addr, data, e_strb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_write_data = '0; cmd_strobe = '0;
    rsp_ready = 1'b0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, rsp_read_data, rsp_status, apb.psel, apb.penable, apb.paddr,
         apb.pwrite, apb.pwdata, apb.pstrb} !== '0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h status=%0d psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h, want all 0",
               cmd_ready, rsp_valid, rsp_read_data, rsp_status, apb.psel, apb.penable,
               apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    do_txn("write", 1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_read_wait();
    do_txn("read_wait3", 1'b0, 16'h0004, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
  endtask

  task automatic test_slverr();
    do_txn("slverr", 1'b0, 16'h0020, 32'h0, 4'h3, 1, 1'b1, 32'hCAFE_F00D, 2);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b0, 16'h0030, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA, 0);
    do_txn("pready_at_limit", 1'b0, 16'h0034, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h0BAD_C0DE, 0);
  endtask

  task automatic test_backpressure();
    do_txn("backpressure", 1'b1, 16'h0040, 32'h0102_0304, 4'h5, 0, 1'b0, 32'h0, 5);
  endtask

  task automatic test_reset_mid_access();
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0050;
    apb.pready = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);          // SETUP
    cmd_valid = 1'b0;
    @(negedge clk);          // ACCESS 1
    @(negedge clk);          // ACCESS 2
    tests++;
    if ({apb.psel, apb.penable} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_access_pre: psel=%b penable=%b, want 1 1", apb.psel, apb.penable);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({apb.psel, apb.penable, rsp_valid, cmd_ready, apb.paddr} !== {4'b0000, 16'h0}) begin
      failures++;
      $display("FAIL rst_mid_access: psel=%b penable=%b valid=%b ready=%b paddr=%h, want 0 0 0 0 0000",
               apb.psel, apb.penable, rsp_valid, cmd_ready, apb.paddr);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, apb.psel} !== 3'b100) begin
      failures++;
      $display("FAIL rst_mid_access_release: ready=%b valid=%b psel=%b, want 1 0 0",
               cmd_ready, rsp_valid, apb.psel);
    end
    do_txn("after_reset", 1'b1, 16'h0054, 32'h7777_0000, 4'hC, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int rsps[$];
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'h0060;
    cmd_write_data = 32'h1111_2222; cmd_strobe = 4'hF;
    apb.pready = 1'b1; apb.pslverr = 1'b0;
    rsp_ready = 1'b1;
    cyc = 0;
    while (accepts.size() < 3 && cyc < 40) begin
      if (cmd_ready === 1'b1) accepts.push_back(cyc);
      if (rsp_valid === 1'b1) rsps.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    tests++;
    if (accepts.size() != 3 || rsps.size() < 1) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d rsps=%0d, want 3 and >=1", accepts.size(), rsps.size());
    end else begin
      tests++;
      if ((accepts[1] - accepts[0]) != 4 || (accepts[2] - accepts[1]) != 4) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d/%0d, want 4/4",
                 accepts[1] - accepts[0], accepts[2] - accepts[1]);
      end
      tests++;
      if ((rsps[0] - accepts[0]) != 3) begin
        failures++;
        $display("FAIL b2b_latency: got %0d, want 3", rsps[0] - accepts[0]);
      end
    end
    repeat (6) @(negedge clk);
    apb.pready = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_txn("random", 1'($urandom), AW'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 10)), 1'($urandom), $urandom,
             int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
